lsu_mem_bridge: RTL

Load/store bridge between the core's memory-access stage and the single-port DPI-backed SRAM. It accepts one byte, half or word request per valid/ready handshake and issues exactly one word-aligned SRAM cycle per request. It builds the byte-lane write data and write mask, and extracts plus sign- or zero-extends load data. Results return over a valid/ready response channel. Misaligned or illegal-size requests are rejected without touching memory.

---
 rtl/lsu_mem_bridge.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_bridge.sv
// Load/store bridge: one core request becomes one word-aligned SRAM cycle, with
// byte-lane write steering, load lane extraction/extension and a response channel.
module lsu_mem_bridge (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_valid,
   output logic        mem_wen,
   output logic [31:0] mem_raddr,
   output logic [31:0] mem_waddr,
   output logic [31:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   input  logic [31:0] mem_rdata
);

   // req and resp channels: a transfer occurs on the rising edge where valid and
   // ready are both high; the producer holds valid and its payload until then.
   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

   state_t      state, state_d;

   logic        wen_q, wen_d;
   logic [1:0]  off_q, off_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;

   logic        mem_valid_d, mem_wen_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_d;
   logic [7:0]  mem_wmask_d;
   logic        resp_valid_d, resp_err_d;
   logic [31:0] resp_rdata_d;

   logic        req_err;
   logic [3:0]  base_mask;
   logic [3:0]  lane_mask;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_fmt;

   assign req_ready = (state == IDLE) && !rst;
   assign mem_raddr = mem_addr_q;
   assign mem_waddr = mem_addr_q;

   always_comb begin
      req_err = 1'b0;
      case (req_size)
         2'd1:    req_err = req_addr[0];
         2'd2:    req_err = |req_addr[1:0];
         2'd3:    req_err = 1'b1;
         default: req_err = 1'b0;
      endcase
   end

   always_comb begin
      base_mask = 4'b1111;
      case (req_size)
         2'd0:    base_mask = 4'b0001;
         2'd1:    base_mask = 4'b0011;
         default: base_mask = 4'b1111;
      endcase
      lane_mask = base_mask << req_addr[1:0];
   end

   // Lane selection uses the offset captured at accept, not the live request.
   always_comb begin
      byte_lane = mem_rdata[{off_q, 3'b000} +: 8];
      half_lane = mem_rdata[{off_q[1], 4'b0000} +: 16];
      load_fmt  = mem_rdata;
      case (size_q)
         2'd0:    load_fmt = {{24{byte_lane[7] & ~uns_q}}, byte_lane};
         2'd1:    load_fmt = {{16{half_lane[15] & ~uns_q}}, half_lane};
         default: load_fmt = mem_rdata;
      endcase
   end

   always_comb begin
      state_d      = state;
      wen_d        = wen_q;
      off_d        = off_q;
      size_d       = size_q;
      uns_d        = uns_q;
      mem_valid_d  = 1'b0;
      mem_wen_d    = 1'b0;
      mem_addr_d   = 32'h0;
      mem_wdata_d  = 32'h0;
      mem_wmask_d  = 8'h00;
      resp_valid_d = resp_valid;
      resp_err_d   = resp_err;
      resp_rdata_d = resp_rdata;
      case (state)
         IDLE: begin
            if (req_valid) begin
               wen_d  = req_wen;
               off_d  = req_addr[1:0];
               size_d = req_size;
               uns_d  = req_unsigned;
               if (req_err) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = 32'h0;
               end else begin
                  state_d     = ISSUE;
                  mem_valid_d = 1'b1;
                  mem_wen_d   = req_wen;
                  mem_addr_d  = {req_addr[31:2], 2'b00};
                  if (req_wen) begin
                     mem_wdata_d = req_wdata << {req_addr[1:0], 3'b000};
                     mem_wmask_d = {4'b0000, lane_mask};
                  end
               end
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = wen_q ? 32'h0 : load_fmt;
         end
         RESP: begin
            if (resp_ready) begin
               state_d      = IDLE;
               resp_valid_d = 1'b0;
               resp_err_d   = 1'b0;
               resp_rdata_d = 32'h0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         wen_q      <= 1'b0;
         off_q      <= 2'd0;
         size_q     <= 2'd0;
         uns_q      <= 1'b0;
         mem_valid  <= 1'b0;
         mem_wen    <= 1'b0;
         mem_addr_q <= 32'h0;
         mem_wdata  <= 32'h0;
         mem_wmask  <= 8'h00;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'h0;
      end else begin
         state      <= state_d;
         wen_q      <= wen_d;
         off_q      <= off_d;
         size_q     <= size_d;
         uns_q      <= uns_d;
         mem_valid  <= mem_valid_d;
         mem_wen    <= mem_wen_d;
         mem_addr_q <= mem_addr_d;
         mem_wdata  <= mem_wdata_d;
         mem_wmask  <= mem_wmask_d;
         resp_valid <= resp_valid_d;
         resp_err   <= resp_err_d;
         resp_rdata <= resp_rdata_d;
      end
   end

endmodule
